clock_enable_gen: RTL and testbench
===================================

Name: clock_enable_gen

Overview:
- Multi-channel, runtime-programmable clock divider for the FFT datapath.
- Each channel produces two signals from a single i_clk domain: a single-cycle strobe (o_stb), used as a clock enable, and a registered divided square wave (o_clk_div).
- Reset defaults give /2, /4, /8, /16 on channels 0..3, so existing consumers see the same rates out of reset.
- Adds per-channel divisor reprogramming at period boundaries, a global run enable and a global phase-sync.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16)
- DIV_W, 8, divisor width in bits; must satisfy DIV_W >= NUM_CH+1
- SEL_W, $clog2(NUM_CH) (minimum 1), width of the channel-select field

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset
- i_en  in  1  global run enable; counters advance only while high
- i_sync  in  1  single-cycle pulse; restarts the phase of all channels together
- i_div_wr  in  1  divisor write strobe
- i_div_sel  in  SEL_W  channel index for the write
- i_div_val  in  DIV_W  new divisor D (0 = channel off)
- o_stb  out  NUM_CH  per-channel strobe, 1 cycle per D enabled cycles
- o_clk_div  out  NUM_CH  per-channel divided square wave (registered)
- o_pend  out  NUM_CH  per-channel flag: a divisor update is waiting to be applied

Behaviour:
- Reset i_rst, asynchronous, active-high; clock i_clk.
- Per-channel state: phase p (DIV_W bits), active divisor D, pending divisor Dp, pending flag.
- Reset values:
  - p=0; D=Dp=2^(i+1) for channel i; pend=0.
  - o_stb=0, o_clk_div=0, o_pend=0.
- Normal edge (i_en=1, i_sync=0, D>=1):
  - p_next = (p==D-1) ? 0 : p+1.
  - o_stb <= (p==D-1).
  - o_clk_div <= (p_next >= D>>1).
  - Result: o_stb first asserts on the D-th enabled edge after reset, then every D edges.
  - With the default D=2^(i+1), o_clk_div is bit i of a free-running binary counter.
- D=1: o_stb constantly 1 while enabled; o_clk_div constantly 1.
- D=0 (channel off): p held at 0; o_stb <= 0; o_clk_div <= 0.
- i_en=0: p and o_clk_div hold; o_stb <= 0. Pending updates are not applied.
- Divisor write (i_div_wr=1):
  - Dp[sel] <= i_div_val; pend[sel] <= 1.
  - If i_div_sel >= NUM_CH, the write is ignored.
- Divisor application:
  - Dp is copied to D and pend clears on the terminal-count edge (i_en=1 and p==D-1). That edge resets p to 0 and asserts o_stb as normal, so no short or runt period is ever generated.
  - If D==0 (channel off), Dp is applied on the next edge, independent of i_en. p stays 0. The new period starts counting from the next enabled edge.
- Write on the same edge as the terminal count of the same channel: the written value (not the old Dp) becomes D on that edge, and pend ends at 0.
- Consecutive writes before application: the last write wins.
- i_sync=1 (any i_en), all channels:
  - If pend, D <= Dp, including a write arriving on the same edge.
  - p <= 0; o_stb <= 0; o_clk_div <= (D_new==1); pend <= 0.
- Priority on a given edge: reset > sync > terminal-count update > normal count.
- Asynchronous reset mid-period: all state returns to reset values immediately; programmed divisors are lost.
- All outputs are flops; no combinational path from inputs to outputs.

Decomposition:
- Package clock_enable_pkg:
  - function default_div(ch) = 2^(ch+1)
  - DIV_OFF = 0 constant
  - function sel_width(n)
- Sub-module clock_enable_channel: one channel's phase counter, shadow register, apply logic and output flops.
- The top level generates NUM_CH instances and decodes i_div_sel into per-channel write strobes.

Test Plan:
- Reset release, i_en=1 for 32 cycles, default divisors:
  - o_clk_div[0..3] match bits 0..3 of a reference up-counter.
  - o_stb[3] pulses on edges 16 and 32 only.
- Write ch1=3 at cycle 5 (D=4, mid-period):
  - o_pend[1]=1 until edge 8.
  - Strobe intervals are 4 then 3,3,3; o_clk_div[1] pattern 0,1,1 repeating; no period shorter than 3.
- Write ch0=0, then later ch0=5 with i_en=0:
  - After the first write, o_stb[0]=o_clk_div[0]=0.
  - After the second, D=5 is applied within 1 edge; the first strobe comes 5 enabled edges after i_en rises.
- i_sync at cycle 11 with a same-edge write ch2=6:
  - All p=0, o_stb=0 next cycle.
  - Ch2 strobes every 6 cycles from then on; all channels phase-aligned.
- i_en toggled low for 7 cycles mid-period: o_clk_div holds, o_stb stays 0, and the remaining phase resumes exactly where it stopped.
- Write with i_div_sel=NUM_CH, and assert i_rst mid-period:
  - The out-of-range write causes no state change.
  - Reset immediately zeroes the outputs; defaults /2../16 are restored.

Source files
------------

// File: rtl/clock_enable_pkg.sv
// Shared constants and helpers for the multi-channel clock-enable generator.
// Channel i defaults to divide-by-2^(i+1) so consumers see fixed rates out of reset.
package clock_enable_pkg;

   localparam int DIV_OFF = 0;

   // Which branch a channel takes on the coming edge, in priority order.
   typedef enum logic [1:0] {
      MODE_SYNC,
      MODE_OFF,
      MODE_RUN,
      MODE_HOLD
   } ch_mode_e;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int default_div(input int ch);
      return 1 << (ch + 1);
   endfunction

endpackage

// File: rtl/clock_enable_channel.sv
// One divider channel: phase counter, shadow divisor, boundary-aligned apply, output flops.
// A new divisor only takes effect on a terminal count, a sync, or while the channel is off.
module clock_enable_channel
   import clock_enable_pkg::*;
#(
   parameter int               DIV_W   = 8,
   parameter logic [DIV_W-1:0] RST_DIV = DIV_W'(2)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_sync,
   input  logic             i_wr,
   input  logic [DIV_W-1:0] i_wr_val,
   output logic             o_stb,
   output logic             o_clk_div,
   output logic             o_pend
);

   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
   localparam logic [DIV_W-1:0] OFF = DIV_W'(DIV_OFF);

   logic [DIV_W-1:0] r_p;
   logic [DIV_W-1:0] r_d;
   logic [DIV_W-1:0] r_dp;
   logic             r_pend;
   logic             r_stb;
   logic             r_clk_div;

   logic [DIV_W-1:0] w_dp_eff;
   logic             w_pend_eff;
   logic             w_tc;
   logic [DIV_W-1:0] w_p_inc;
   ch_mode_e         w_mode;

   logic [DIV_W-1:0] w_p_nxt;
   logic [DIV_W-1:0] w_d_nxt;
   logic             w_pend_nxt;
   logic             w_stb_nxt;
   logic             w_clk_nxt;

   // A same-edge write is folded in here so it beats the older shadow value.
   assign w_dp_eff   = i_wr ? i_wr_val : r_dp;
   assign w_pend_eff = i_wr | r_pend;
   assign w_tc       = (r_p == (r_d - ONE));
   assign w_p_inc    = w_tc ? '0 : (r_p + ONE);

   always_comb begin
      w_mode = MODE_HOLD;
      if (i_sync) begin
         w_mode = MODE_SYNC;
      end else if (r_d == OFF) begin
         w_mode = MODE_OFF;
      end else if (i_en) begin
         w_mode = MODE_RUN;
      end
   end

   always_comb begin
      w_p_nxt    = r_p;
      w_d_nxt    = r_d;
      w_pend_nxt = w_pend_eff;
      w_stb_nxt  = 1'b0;
      w_clk_nxt  = r_clk_div;
      unique case (w_mode)
         MODE_SYNC: begin
            w_d_nxt    = w_pend_eff ? w_dp_eff : r_d;
            w_p_nxt    = '0;
            w_clk_nxt  = (w_d_nxt == ONE);
            w_pend_nxt = 1'b0;
         end
         MODE_OFF: begin
            // An off channel has no boundary to wait for, so apply a parked divisor at once.
            w_p_nxt   = '0;
            w_clk_nxt = 1'b0;
            if (r_pend) begin
               w_d_nxt    = w_dp_eff;
               w_pend_nxt = 1'b0;
            end
         end
         MODE_RUN: begin
            w_p_nxt   = w_p_inc;
            w_stb_nxt = w_tc;
            w_clk_nxt = (w_p_inc >= (r_d >> 1));
            if (w_tc && w_pend_eff) begin
               w_d_nxt    = w_dp_eff;
               w_pend_nxt = 1'b0;
            end
         end
         MODE_HOLD: begin
            w_stb_nxt = 1'b0;
         end
         default: begin
            w_stb_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_p       <= '0;
         r_d       <= RST_DIV;
         r_dp      <= RST_DIV;
         r_pend    <= 1'b0;
         r_stb     <= 1'b0;
         r_clk_div <= 1'b0;
      end else begin
         r_p       <= w_p_nxt;
         r_d       <= w_d_nxt;
         r_dp      <= w_dp_eff;
         r_pend    <= w_pend_nxt;
         r_stb     <= w_stb_nxt;
         r_clk_div <= w_clk_nxt;
      end
   end

   assign o_stb     = r_stb;
   assign o_clk_div = r_clk_div;
   assign o_pend    = r_pend;

endmodule

// File: rtl/clock_enable_gen.sv
// Multi-channel programmable clock-enable generator for the FFT datapath.
// Decodes the divisor write port into per-channel strobes and replicates the channel.
module clock_enable_gen
   import clock_enable_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DIV_W  = 8,
   parameter int SEL_W  = sel_width(NUM_CH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_sync,
   input  logic              i_div_wr,
   input  logic [SEL_W-1:0]  i_div_sel,
   input  logic [DIV_W-1:0]  i_div_val,
   output logic [NUM_CH-1:0] o_stb,
   output logic [NUM_CH-1:0] o_clk_div,
   output logic [NUM_CH-1:0] o_pend
);

   if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_bad_num_ch
      $error("clock_enable_gen: NUM_CH must be in 1..16");
   end
   if (DIV_W < (NUM_CH + 1)) begin : g_bad_div_w
      $error("clock_enable_gen: DIV_W too narrow for the default divisors");
   end

   // i_div_wr is a single-cycle strobe with no back-pressure: it is always accepted,
   // and a select that matches no channel simply addresses nothing.
   logic [NUM_CH-1:0] w_wr;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam logic [DIV_W-1:0] L_RST_DIV = DIV_W'(default_div(gi));

      assign w_wr[gi] = i_div_wr && (i_div_sel == SEL_W'(gi));

      clock_enable_channel #(
         .DIV_W   (DIV_W),
         .RST_DIV (L_RST_DIV)
      ) u_ch (
         .i_clk     (i_clk),
         .i_rst     (i_rst),
         .i_en      (i_en),
         .i_sync    (i_sync),
         .i_wr      (w_wr[gi]),
         .i_wr_val  (i_div_val),
         .o_stb     (o_stb[gi]),
         .o_clk_div (o_clk_div[gi]),
         .o_pend    (o_pend[gi])
      );
   end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen: a cycle model feeds an expected queue, plus
// independent checks against reference counters and hand-derived strobe positions.
module tb_clock_enable_gen;
   import clock_enable_pkg::*;

   localparam int NUM_CH = 4;
   localparam int N3     = 3;
   localparam int DIV_W  = 8;
   localparam int SEL_W  = 2;
   localparam int NM     = NUM_CH + N3;
   localparam int W      = 3 * NM;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic              i_en;
   logic              i_sync;
   logic              i_div_wr;
   logic [SEL_W-1:0]  i_div_sel;
   logic [SEL_W-1:0]  sel3;
   logic [DIV_W-1:0]  i_div_val;
   logic [NUM_CH-1:0] o_stb, o_clk_div, o_pend;
   logic [N3-1:0]     o_stb3, o_clk3, o_pend3;

   int                n_tests = 0;
   int                n_fail  = 0;
   logic [W-1:0]      exp_q[$];
   int                stb_edges[$];
   int                exp_edges[5] = '{4, 8, 11, 14, 17};
   int                en_cnt;
   logic              en_now;
   logic [NUM_CH-1:0] held;

   int                m_p[NM], m_d[NM], m_dp[NM];
   bit                m_pend[NM], m_stb[NM], m_clk[NM];

   always #5 i_clk = ~i_clk;

   clock_enable_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) u_dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_sync(i_sync),
      .i_div_wr(i_div_wr), .i_div_sel(i_div_sel), .i_div_val(i_div_val),
      .o_stb(o_stb), .o_clk_div(o_clk_div), .o_pend(o_pend)
   );

   // Three-channel copy whose select is parked at 3, an index it does not have.
   clock_enable_gen #(.NUM_CH(N3), .DIV_W(DIV_W)) u_dut3 (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_sync(i_sync),
      .i_div_wr(i_div_wr), .i_div_sel(sel3), .i_div_val(i_div_val),
      .o_stb(o_stb3), .o_clk_div(o_clk3), .o_pend(o_pend3)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NM; c++) begin
         m_d[c]    = (c < NUM_CH) ? default_div(c) : default_div(c - NUM_CH);
         m_dp[c]   = m_d[c];
         m_p[c]    = 0;
         m_pend[c] = 0;
         m_stb[c]  = 0;
         m_clk[c]  = 0;
      end
   endtask

   task automatic model_edge();
      logic [W-1:0] e;
      bit           wr_c, pend_any, tc;
      int           dp_new, p_new;
      e = '0;
      if (i_rst) begin
         model_reset();
      end else begin
         for (int c = 0; c < NM; c++) begin
            wr_c = i_div_wr && ((c < NUM_CH) ? (int'(i_div_sel) == c) : (int'(sel3) == c - NUM_CH));
            dp_new   = wr_c ? int'(i_div_val) : m_dp[c];
            pend_any = wr_c || m_pend[c];
            if (i_sync) begin
               if (pend_any) m_d[c] = dp_new;
               m_p[c] = 0; m_stb[c] = 0; m_clk[c] = (m_d[c] == 1); m_pend[c] = 0;
            end else if (m_d[c] == 0) begin
               m_p[c] = 0; m_stb[c] = 0; m_clk[c] = 0;
               if (m_pend[c]) begin
                  m_d[c] = dp_new; m_pend[c] = 0;
               end else begin
                  m_pend[c] = wr_c;
               end
            end else if (i_en) begin
               tc         = (m_p[c] == m_d[c] - 1);
               p_new      = tc ? 0 : m_p[c] + 1;
               m_stb[c]   = tc;
               m_clk[c]   = (p_new >= m_d[c] / 2);
               m_p[c]     = p_new;
               if (tc && pend_any) begin
                  m_d[c] = dp_new; m_pend[c] = 0;
               end else begin
                  m_pend[c] = pend_any;
               end
            end else begin
               m_stb[c]  = 0;
               m_pend[c] = pend_any;
            end
            m_dp[c] = dp_new;
            e[c]        = m_stb[c];
            e[NM + c]   = m_clk[c];
            e[2*NM + c] = m_pend[c];
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic step();
      logic [W-1:0] e;
      model_edge();
      @(posedge i_clk);
      #1;
      e = exp_q.pop_front();
      check("sb_stb",  16'({o_stb3, o_stb}),      16'(e[NM-1:0]));
      check("sb_clk",  16'({o_clk3, o_clk_div}),  16'(e[2*NM-1:NM]));
      check("sb_pend", 16'({o_pend3, o_pend}),    16'(e[3*NM-1:2*NM]));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst = 1'b1; i_en = 1'b0; i_sync = 1'b0; i_div_wr = 1'b0;
      i_div_sel = '0; i_div_val = '0; sel3 = 2'd3;
      model_reset();
      repeat (2) step();
      check("rst_stb",  16'(o_stb),     16'd0);
      check("rst_clk",  16'(o_clk_div), 16'd0);
      check("rst_pend", 16'(o_pend),    16'd0);
      i_rst = 1'b0;

      // Default rates: outputs track a binary up-counter.
      i_en = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         step();
         check("t1_clkdiv", 16'(o_clk_div), 16'(k[3:0]));
         check("t1_stb3",   16'(o_stb[3]),  16'(k == 16 || k == 32));
      end

      // Mid-period rewrite of ch1 from 4 to 3.
      for (int k = 1; k <= 18; k++) begin
         if (k == 6) begin
            i_div_wr = 1'b1; i_div_sel = 2'd1; i_div_val = 8'd3;
         end
         step();
         i_div_wr = 1'b0;
         if (o_stb[1]) stb_edges.push_back(k);
         check("t2_pend1", 16'(o_pend[1]), 16'(k == 6 || k == 7));
      end
      check("t2_nstb", 16'(stb_edges.size()), 16'd5);
      for (int i = 0; i < 5; i++) begin
         check("t2_stb_edge", 16'(stb_edges[i]), 16'(exp_edges[i]));
      end

      // Turn ch0 off, then program /5 while stopped.
      i_div_wr = 1'b1; i_div_sel = 2'd0; i_div_val = 8'd0;
      step();
      i_div_wr = 1'b0;
      step();
      for (int k = 0; k < 2; k++) begin
         step();
         check("t3_off_stb", 16'(o_stb[0]),     16'd0);
         check("t3_off_clk", 16'(o_clk_div[0]), 16'd0);
      end
      i_en = 1'b0;
      i_div_wr = 1'b1; i_div_sel = 2'd0; i_div_val = 8'd5;
      step();
      i_div_wr = 1'b0;
      check("t3_pend_set", 16'(o_pend[0]), 16'd1);
      step();
      check("t3_pend_clr", 16'(o_pend[0]), 16'd0);
      repeat (2) step();
      i_en = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         check("t3_first_stb", 16'(o_stb[0]), 16'(k == 5));
      end

      // Sync with a same-edge write to ch2, then an enable gap.
      repeat (4) step();
      i_sync = 1'b1; i_div_wr = 1'b1; i_div_sel = 2'd2; i_div_val = 8'd6;
      step();
      i_sync = 1'b0; i_div_wr = 1'b0;
      check("t4_sync_stb",  16'(o_stb),     16'd0);
      check("t4_sync_clk",  16'(o_clk_div), 16'd0);
      check("t4_sync_pend", 16'(o_pend),    16'd0);
      en_cnt = 0;
      for (int k = 1; k <= 30; k++) begin
         if (k == 10) begin
            i_en = 1'b0; held = o_clk_div;
         end
         if (k == 17) i_en = 1'b1;
         en_now = i_en;
         step();
         if (en_now) en_cnt++;
         check("t4_stb0", 16'(o_stb[0]), 16'(en_now && (en_cnt % 5 == 0)));
         check("t4_stb1", 16'(o_stb[1]), 16'(en_now && (en_cnt % 3 == 0)));
         check("t4_stb2", 16'(o_stb[2]), 16'(en_now && (en_cnt % 6 == 0)));
         check("t4_stb3", 16'(o_stb[3]), 16'(en_now && (en_cnt % 16 == 0)));
         if (!en_now) check("t5_hold", 16'(o_clk_div), 16'(held));
      end

      // Out-of-range select on the 3-channel copy, then reset mid-period.
      i_div_wr = 1'b1; i_div_sel = 2'd3; i_div_val = 8'd1;
      step();
      i_div_wr = 1'b0;
      check("t6_pend3_main", 16'(o_pend[3]), 16'd1);
      check("t6_oor_pend",   16'(o_pend3),   16'd0);
      repeat (3) step();
      #2;
      i_rst = 1'b1;
      #1;
      check("t6_arst_stb",  16'({o_stb3, o_stb}),     16'd0);
      check("t6_arst_clk",  16'({o_clk3, o_clk_div}), 16'd0);
      check("t6_arst_pend", 16'({o_pend3, o_pend}),   16'd0);
      model_reset();
      step();
      i_rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         step();
         check("t6_def_clk",  16'(o_clk_div), 16'(k[3:0]));
         check("t6_def_stb3", 16'(o_stb[3]),  16'(k == 16));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
